// File: rtl/lif_bank.sv
// Time-multiplexed bank of leaky integrate-and-fire neurons.
// One channel is updated per enabled cycle, round-robin.
module lif_bank #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 8,
  parameter int THRESH_DEF = 200,
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH*WIDTH-1:0] current,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_sel,
  input  logic [WIDTH-1:0]        cfg_data,
  input  logic                    clr_flags,
  output logic [WIDTH-1:0]        state_out,
  output logic [PW-1:0]           ch_out,
  output logic                    spike,
  output logic [NUM_CH-1:0]       spike_flags
);

  logic [WIDTH-1:0] state      [NUM_CH];
  logic [3:0]       refrac_cnt [NUM_CH];
  logic [WIDTH-1:0] threshold;
  logic [2:0]       leak_shift;
  logic [3:0]       refrac_period;
  logic [PW-1:0]    ptr;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] st;
  logic [3:0]       rc;
  logic [WIDTH-1:0] leaked;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sat;
  logic             in_ref;
  logic             fire;
  logic [WIDTH-1:0] nxt_state;

  // Datapath for the channel currently selected by ptr.
  always_comb begin
    cur       = current[WIDTH*int'(ptr) +: WIDTH];
    st        = state[ptr];
    rc        = refrac_cnt[ptr];
    leaked    = st - (st >> leak_shift);
    sum       = {1'b0, leaked} + {1'b0, cur};
    sat       = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    in_ref    = (rc != 4'd0);
    fire      = !in_ref && (sat >= threshold);
    nxt_state = (in_ref || fire) ? '0 : sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]      <= '0;
        refrac_cnt[i] <= '0;
      end
      threshold     <= WIDTH'(THRESH_DEF);
      leak_shift    <= 3'd1;
      refrac_period <= 4'd2;
      ptr           <= '0;
      state_out     <= '0;
      ch_out        <= '0;
      spike         <= 1'b0;
      spike_flags   <= '0;
    end else begin
      spike <= 1'b0;
      if (en) begin
        state[ptr] <= nxt_state;
        if (in_ref)
          refrac_cnt[ptr] <= rc - 4'd1;
        else if (fire)
          refrac_cnt[ptr] <= refrac_period;
        state_out <= nxt_state;
        ch_out    <= ptr;
        spike     <= fire;
        ptr       <= ptr + 1'b1;
      end
      if (cfg_we) begin
        unique case (1'b1)
          cfg_sel == 2'd0: threshold     <= cfg_data;
          cfg_sel == 2'd1: leak_shift    <= cfg_data[2:0];
          cfg_sel == 2'd2: refrac_period <= cfg_data[3:0];
          default: ;
        endcase
      end
      // A fire on the clearing edge still leaves its flag set.
      if (clr_flags)
        spike_flags <= '0;
      if (en && fire)
        spike_flags[ptr] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lif_bank.sv
// Directed-vector bench for lif_bank with default parameters.
// Expected values are hand-computed per channel update.
module tb_lif_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] current;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [7:0]  cfg_data;
  logic        clr_flags;
  logic [7:0]  state_out;
  logic [1:0]  ch_out;
  logic        spike;
  logic [3:0]  spike_flags;

  int n_chk = 0;
  int n_err = 0;

  lif_bank dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .current(current),
    .cfg_we(cfg_we),
    .cfg_sel(cfg_sel),
    .cfg_data(cfg_data),
    .clr_flags(clr_flags),
    .state_out(state_out),
    .ch_out(ch_out),
    .spike(spike),
    .spike_flags(spike_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input string tag, input int ch,
                     input int st, input int sp);
    chk({tag, " ch"}, 32'(ch_out), 32'(ch));
    chk({tag, " st"}, 32'(state_out), 32'(st));
    chk({tag, " sp"}, 32'(spike), 32'(sp));
  endtask

  int exp_st [5] = '{150, 0, 0, 0, 150};
  int exp_sp [5] = '{0, 1, 0, 0, 0};

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    current   = '0;
    cfg_we    = 1'b0;
    cfg_sel   = 2'd0;
    cfg_data  = '0;
    clr_flags = 1'b0;
    repeat (2) step();
    upd("rst0", 0, 0, 0);
    chk("rst0 flags", 32'(spike_flags), 32'd0);

    // fire / refractory on ch0
    rst_n   = 1'b1;
    en      = 1'b1;
    current = {8'd0, 8'd0, 8'd0, 8'd150};
    for (int i = 0; i < 5; i++) begin
      step();
      upd($sformatf("fire%0d", i), 0, exp_st[i], exp_sp[i]);
      repeat (3) step();
    end
    chk("fire flags", 32'(spike_flags), 32'd1);

    // en gating: ch0 150 -> 75+10 = 85
    current = {8'd0, 8'd0, 8'd0, 8'd10};
    step();
    upd("gate pre", 0, 85, 0);
    en      = 1'b0;
    current = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      upd($sformatf("gate%0d", i), 0, 85, 0);
    end
    en      = 1'b1;
    current = {8'd0, 8'd0, 8'd7, 8'd0};
    step();
    upd("gate resume", 1, 7, 0);
    current = '0;
    repeat (2) step();
    step();
    upd("gate ch0", 0, 43, 0);

    // saturation with threshold 255, cfg written while en=0
    en       = 1'b0;
    cfg_we   = 1'b1;
    cfg_sel  = 2'd0;
    cfg_data = 8'd255;
    step();
    upd("cfg hold", 0, 43, 0);
    cfg_we  = 1'b0;
    en      = 1'b1;
    current = {8'd0, 8'd0, 8'd196, 8'd0};
    step();
    upd("sat pre", 1, 200, 0);
    current = '0;
    repeat (2) step();
    step();
    upd("sat ch0", 0, 22, 0);
    current = {8'd0, 8'd0, 8'd255, 8'd0};
    step();
    upd("sat fire", 1, 0, 1);
    chk("sat flags", 32'(spike_flags), 32'd3);

    // clear vs set on the same edge
    current   = {8'd0, 8'd255, 8'd0, 8'd0};
    clr_flags = 1'b1;
    step();
    upd("clr fire", 2, 0, 1);
    chk("clr set wins", 32'(spike_flags), 32'd4);
    current = '0;
    step();
    chk("clr only", 32'(spike_flags), 32'd0);
    clr_flags = 1'b0;

    // leak_shift write lands on ch0's own update edge
    current  = {8'd0, 8'd0, 8'd255, 8'd10};
    cfg_we   = 1'b1;
    cfg_sel  = 2'd1;
    cfg_data = 8'd0;
    step();
    upd("cfg old", 0, 21, 0);
    cfg_we = 1'b0;
    step();
    upd("refrac ign", 1, 0, 0);
    current = {8'd0, 8'd0, 8'd0, 8'd10};
    repeat (2) step();
    step();
    upd("cfg new", 0, 10, 0);
    current = '0;
    step();
    upd("pre rst", 1, 0, 0);

    // asynchronous reset mid-run; ch2 refractory is abandoned
    rst_n = 1'b0;
    #2;
    upd("rst mid", 0, 0, 0);
    chk("rst mid flags", 32'(spike_flags), 32'd0);
    current = {8'd0, 8'd210, 8'd0, 8'd50};
    #1;
    rst_n = 1'b1;
    step();
    upd("rst ch0", 0, 50, 0);
    step();
    upd("rst ch1", 1, 0, 0);
    step();
    upd("rst ch2", 2, 0, 1);
    chk("rst flags", 32'(spike_flags), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
